// File: rtl/core_dmem_responder.sv
// Tightly coupled data RAM behind the core dmem request/grant interface.
// Adds programmable wait states, applies byte strobes and flags bad accesses.
module core_dmem_responder #(
   parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0001_0000,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        dmem_req,
   input  logic [63:0] dmem_addr,
   input  logic        dmem_wen,
   input  logic [7:0]  dmem_strb,
   input  logic [63:0] dmem_wdata,
   input  logic        stall,
   output logic        dmem_gnt,
   output logic        dmem_err,
   output logic [63:0] dmem_rdata
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [63:0] END_ADDR = BASE_ADDR + (64'(DEPTH) << 3);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gnt_c;
   logic             bad_c;
   logic             wr_en_c;
   logic [63:0]      offset_c;
   logic [IDX_W-1:0] idx_c;
   logic [63:0]      mem_q [DEPTH];

   // Address decode: range and alignment check plus word index
   always_comb begin
      offset_c = dmem_addr - BASE_ADDR;
      idx_c    = IDX_W'(offset_c >> 3);
      bad_c    = (dmem_addr < BASE_ADDR) || (dmem_addr >= END_ADDR) ||
                 (dmem_addr[2:0] != 3'b000);
   end

   // Wait-state sequencing; zero wait states grant combinationally from IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_c   = 1'b0;
      if (WAIT_CYCLES == 0) begin
         gnt_c = dmem_req && !stall;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (dmem_req) begin
                  cnt_d   = CNT_LOAD;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!dmem_req) begin
                  state_d = ST_IDLE;
               end else if (!stall) begin
                  if (cnt_q == '0) begin
                     gnt_c   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset also masks the zero-wait combinational grant path
   always_comb begin
      dmem_gnt   = gnt_c && g_resetn;
      dmem_err   = dmem_gnt && bad_c;
      wr_en_c    = dmem_gnt && dmem_wen && !bad_c;
      dmem_rdata = (dmem_gnt && !dmem_wen && !bad_c) ? mem_q[idx_c] : 64'd0;
   end

   // Array contents survive reset
   always_ff @(posedge g_clk) begin
      if (wr_en_c) begin
         for (int n = 0; n < 8; n++) begin
            if (dmem_strb[n]) begin
               mem_q[idx_c][8*n +: 8] <= dmem_wdata[8*n +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_core_dmem_responder.sv
// Scoreboard bench for core_dmem_responder: four instances with 1, 3, 2 and 0 wait states.
module tb_core_dmem_responder;

   localparam int NI = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NI-1:0] req, wen, stall, gnt, err;
   logic [63:0]   addr  [NI];
   logic [63:0]   wdata [NI];
   logic [63:0]   rdata [NI];
   logic [7:0]    strb  [NI];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          inst;
      logic [63:0] rd;
      logic        er;
      int          cy;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      core_dmem_responder #(
         .BASE_ADDR  (64'h0000_0000_0001_0000),
         .DEPTH      (1024),
         .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 0)
      ) u_dut (
         .g_clk     (clk),
         .g_resetn  (rst_n),
         .dmem_req  (req[g]),
         .dmem_addr (addr[g]),
         .dmem_wen  (wen[g]),
         .dmem_strb (strb[g]),
         .dmem_wdata(wdata[g]),
         .stall     (stall[g]),
         .dmem_gnt  (gnt[g]),
         .dmem_err  (err[g]),
         .dmem_rdata(rdata[g])
      );
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wc(input int g);
      case (g)
         0:       return 1;
         1:       return 3;
         2:       return 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [63:0] pat(input int i);
      return 64'h0101_0101_0101_0101 * 64'(i + 1);
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endfunction

   // Monitor: every grant pops one expectation; outside grants outputs must be quiet
   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (gnt[g]) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_gnt inst %0d at cycle %0d", g, cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("gnt_inst", 64'(g), 64'(mon_e.inst));
               chk("gnt_cycle", 64'(cyc), 64'(mon_e.cy));
               chk("rdata", rdata[g], mon_e.rd);
               chk("err", 64'(err[g]), 64'(mon_e.er));
            end
         end else begin
            chk("idle_out", rdata[g] | 64'(err[g]), 64'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one request (entered at posedge+1) and hold it until granted
   task automatic run(input int g, input logic [63:0] a, input logic w, input logic [7:0] s,
                      input logic [63:0] d, input logic [63:0] xrd, input logic xer,
                      input int st_from, input int st_len);
      int k;
      int off;
      bit done;
      k        = cyc;
      addr[g]  = a;
      wen[g]   = w;
      strb[g]  = s;
      wdata[g] = d;
      req[g]   = 1'b1;
      sb.push_back('{g, xrd, xer, k + wc(g) + st_len});
      stall[g] = (st_len > 0) && (st_from == 0);
      done     = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = gnt[g];
         @(posedge clk);
         #1;
         off      = cyc - k;
         stall[g] = (off >= st_from) && (off < st_from + st_len);
      end
      req[g]   = 1'b0;
      stall[g] = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout inst %0d addr %h: got no gnt, expected gnt by cycle %0d",
                  g, a, k + wc(g) + st_len);
      end
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      req   = '0;
      wen   = '0;
      stall = '0;
      for (int g = 0; g < NI; g++) begin
         addr[g]  = 64'h1_0000;
         wdata[g] = '0;
         strb[g]  = '0;
      end

      // Reset must mask even the zero-wait combinational grant
      req[3] = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_gnt", 64'(gnt[3]), 64'd0);
      chk("reset_err", 64'(err[3]), 64'd0);
      chk("reset_rdata", rdata[3], 64'd0);
      req[3] = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // One wait state: full write, strobed write, range and alignment errors
      run(0, 64'h1_0008, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 0, 0);
      run(0, 64'h1_0008, 1'b0, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 0, 0);
      run(0, 64'h1_0008, 1'b1, 8'h0C, 64'h0000_0000_AABB_0000, 64'd0, 1'b0, 0, 0);
      run(0, 64'h1_0008, 1'b0, 8'h00, 64'd0, 64'h1122_3344_AABB_7788, 1'b0, 0, 0);
      run(0, 64'h1_1FF8, 1'b1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0, 0, 0);
      run(0, 64'h0_FFF8, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1, 0, 0);
      run(0, 64'h1_2008, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 0);
      run(0, 64'h1_2000, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 0);
      run(0, 64'h1_0009, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1, 0, 0);
      run(0, 64'h1_1FFC, 1'b1, 8'hFF, 64'h0000_0000_0000_0000, 64'd0, 1'b1, 0, 0);
      run(0, 64'h1_1FF8, 1'b0, 8'h00, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0, 0);
      run(0, 64'h1_0008, 1'b1, 8'h00, 64'h5555_5555_5555_5555, 64'd0, 1'b0, 0, 0);
      run(0, 64'h1_0008, 1'b0, 8'h00, 64'd0, 64'h1122_3344_AABB_7788, 1'b0, 0, 0);
      run(0, 64'h1_0000, 1'b1, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 1'b0, 0, 0);
      run(0, 64'h1_0000, 1'b0, 8'h00, 64'd0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 0, 0);

      // Three wait states with a two-cycle stall mid-WAIT
      run(1, 64'h1_0010, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 2, 2);
      run(1, 64'h1_0010, 1'b0, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0);

      // Two wait states: abort and reset mid-WAIT leave the word untouched
      run(2, 64'h1_0018, 1'b1, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 1'b0, 0, 0);
      addr[2]  = 64'h1_0018;
      wen[2]   = 1'b1;
      strb[2]  = 8'hFF;
      wdata[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      req[2]   = 1'b1;
      idle(1);
      req[2] = 1'b0;
      idle(3);
      run(2, 64'h1_0018, 1'b0, 8'h00, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 0, 0);
      wdata[2] = 64'h1111_1111_1111_1111;
      wen[2]   = 1'b1;
      req[2]   = 1'b1;
      idle(1);
      rst_n  = 1'b0;
      req[2] = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      run(2, 64'h1_0018, 1'b0, 8'h00, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 0, 0);

      // Zero wait states: fill four words, then stream back-to-back reads
      for (int i = 0; i < 4; i++) begin
         run(3, 64'h1_0100 + 64'(8 * i), 1'b1, 8'hFF, pat(i), 64'd0, 1'b0, 0, 0);
      end
      k      = cyc;
      wen[3] = 1'b0;
      req[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr[3] = 64'h1_0100 + 64'(8 * i);
         sb.push_back('{3, pat(i), 1'b0, k + i});
         idle(1);
      end
      req[3] = 1'b0;

      idle(4);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
